// File: rtl/lbp_stream.sv
// Streaming 3x3 Local Binary Pattern engine: single-pass raster read, two line
// buffers and a sliding 3x3 window produce one LBP code per captured pixel.
module lbp_stream #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int DW    = 8,
   parameter int AW    = 14
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          gray_ready,
   output logic          gray_req,
   output logic [AW-1:0] gray_addr,
   input  logic [DW-1:0] gray_data,
   input  logic          border_mode,
   output logic [AW-1:0] lbp_addr,
   output logic          lbp_valid,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   localparam int N  = IMG_W * IMG_H;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic [AW-1:0] LAST     = AW'(N - 1);
   localparam logic [AW-1:0] SKEW     = AW'(IMG_W + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   rd_addr_q, rd_addr_d;
   logic            inflight_q, inflight_d;
   logic [AW-1:0]   cap_idx_q, cap_idx_d;
   logic [CW-1:0]   in_col_q, in_col_d;
   logic [AW-1:0]   out_idx_q, out_idx_d;
   logic [CW-1:0]   out_col_q, out_col_d;
   logic [RW-1:0]   out_row_q, out_row_d;
   logic            mode_q, mode_d;
   logic            lbp_valid_q, lbp_valid_d;
   logic [AW-1:0]   lbp_addr_q, lbp_addr_d;
   logic [7:0]      lbp_data_q, lbp_data_d;
   logic            finish_q, finish_d;
   logic [DW-1:0]   win_q [3][3];
   logic [DW-1:0]   win_d [3][3];
   logic [DW-1:0]   lb0_q [IMG_W];
   logic [DW-1:0]   lb1_q [IMG_W];

   logic [DW-1:0]   col_new [3];
   logic [DW-1:0]   nbr [8];
   logic [7:0]      code;
   logic            eval, border;

   // Window is [row][col]; col 2 is newest. The centre of the code being
   // evaluated is win_q[1][2] because the incoming column is one to its right.
   always_comb begin
      col_new[0] = lb1_q[in_col_q];
      col_new[1] = lb0_q[in_col_q];
      col_new[2] = gray_data;
      nbr[0] = win_q[0][1];
      nbr[1] = win_q[0][2];
      nbr[2] = col_new[0];
      nbr[3] = win_q[1][1];
      nbr[4] = col_new[1];
      nbr[5] = win_q[2][1];
      nbr[6] = win_q[2][2];
      nbr[7] = col_new[2];
      code = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         code[i] = (nbr[i] >= win_q[1][2]);
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_addr_d   = rd_addr_q;
      inflight_d  = 1'b0;
      cap_idx_d   = cap_idx_q;
      in_col_d    = in_col_q;
      out_idx_d   = out_idx_q;
      out_col_d   = out_col_q;
      out_row_d   = out_row_q;
      mode_d      = mode_q;
      lbp_valid_d = 1'b0;
      lbp_addr_d  = lbp_addr_q;
      lbp_data_d  = lbp_data_q;
      finish_d    = finish_q | (state_q == DONE);
      win_d       = win_q;

      gray_req = (state_q == RUN) && gray_ready;
      eval     = (inflight_q && (cap_idx_q >= SKEW)) ||
                 ((state_q == DRAIN) && !inflight_q);
      border   = (out_row_q == '0) || (out_row_q == ROW_LAST) ||
                 (out_col_q == '0) || (out_col_q == COL_LAST);

      case (state_q)
         IDLE: begin
            mode_d = border_mode;
            if (gray_ready) state_d = RUN;
         end
         RUN: begin
            if (gray_req) begin
               inflight_d = 1'b1;
               rd_addr_d  = rd_addr_q + AW'(1);
               if (rd_addr_q == LAST) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (eval && (out_idx_q == LAST)) state_d = DONE;
         end
         default: ;
      endcase

      if (inflight_q) begin
         cap_idx_d = cap_idx_q + AW'(1);
         in_col_d  = (in_col_q == COL_LAST) ? '0 : in_col_q + CW'(1);
         for (int unsigned r = 0; r < 3; r++) begin
            // A new row starts with empty left columns so no wrap-around data leaks in.
            win_d[r][0] = (in_col_q == '0) ? '0 : win_q[r][1];
            win_d[r][1] = (in_col_q == '0) ? '0 : win_q[r][2];
            win_d[r][2] = col_new[r];
         end
      end

      if (eval) begin
         lbp_valid_d = !(border && mode_q);
         lbp_addr_d  = out_idx_q;
         lbp_data_d  = border ? 8'h00 : code;
         out_idx_d   = out_idx_q + AW'(1);
         if (out_col_q == COL_LAST) begin
            out_col_d = '0;
            out_row_d = out_row_q + RW'(1);
         end else begin
            out_col_d = out_col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         inflight_q  <= 1'b0;
         cap_idx_q   <= '0;
         in_col_q    <= '0;
         out_idx_q   <= '0;
         out_col_q   <= '0;
         out_row_q   <= '0;
         mode_q      <= 1'b0;
         lbp_valid_q <= 1'b0;
         lbp_addr_q  <= '0;
         lbp_data_q  <= '0;
         finish_q    <= 1'b0;
         win_q       <= '{default: '0};
      end else begin
         state_q     <= state_d;
         rd_addr_q   <= rd_addr_d;
         inflight_q  <= inflight_d;
         cap_idx_q   <= cap_idx_d;
         in_col_q    <= in_col_d;
         out_idx_q   <= out_idx_d;
         out_col_q   <= out_col_d;
         out_row_q   <= out_row_d;
         mode_q      <= mode_d;
         lbp_valid_q <= lbp_valid_d;
         lbp_addr_q  <= lbp_addr_d;
         lbp_data_q  <= lbp_data_d;
         finish_q    <= finish_d;
         win_q       <= win_d;
      end
   end

   always_ff @(posedge clk) begin
      if (inflight_q) begin
         lb1_q[in_col_q] <= lb0_q[in_col_q];
         lb0_q[in_col_q] <= gray_data;
      end
   end

   assign gray_addr = rd_addr_q;
   assign lbp_valid = lbp_valid_q;
   assign lbp_addr  = lbp_addr_q;
   assign lbp_data  = lbp_data_q;
   assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_stream.sv
// Scoreboard bench for lbp_stream on a 16x16 frame: directed images, both
// border modes, a read stall, and a mid-frame reset.
module tb_lbp_stream;

   localparam int W  = 16;
   localparam int H  = 16;
   localparam int N  = W * H;
   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          gray_ready = 1'b0;
   logic          gray_req;
   logic [AW-1:0] gray_addr;
   logic [7:0]    gray_data = 8'h00;
   logic          border_mode = 1'b0;
   logic [AW-1:0] lbp_addr;
   logic          lbp_valid;
   logic [7:0]    lbp_data;
   logic          finish;

   always #5 clk = ~clk;

   lbp_stream #(.IMG_W(W), .IMG_H(H), .DW(8), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .gray_ready(gray_ready),
      .gray_req(gray_req), .gray_addr(gray_addr), .gray_data(gray_data),
      .border_mode(border_mode), .lbp_addr(lbp_addr), .lbp_valid(lbp_valid),
      .lbp_data(lbp_data), .finish(finish)
   );

   typedef struct packed {
      logic [AW-1:0] a;
      logic [7:0]    d;
   } exp_t;

   logic [7:0] img [N];
   exp_t       sbq [$];
   int         checks = 0;
   int         fails = 0;
   int         cyc = 0;
   int         start_cyc = -1;
   int         fin_cyc = -1;
   int         outs = 0;

   // Memory model: data for a request seen before an edge is presented just after it.
   initial begin
      logic          r;
      logic [AW-1:0] a;
      forever begin
         @(negedge clk);
         r = gray_req;
         a = gray_addr;
         @(posedge clk);
         #1;
         gray_data = r ? img[a] : 8'h00;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (reset_n) begin
         if (gray_req && start_cyc < 0) start_cyc = cyc;
         if (finish && fin_cyc < 0) fin_cyc = cyc;
         if (!gray_ready) begin
            checks++;
            if (gray_req) begin
               fails++;
               $display("FAIL req_while_not_ready gray_req=%0b required 0 addr=%0d", gray_req, gray_addr);
            end
         end
         if (lbp_valid) begin
            outs++;
            checks++;
            if (sbq.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write addr=%0d data=%h required no write", lbp_addr, lbp_data);
            end else begin
               e = sbq.pop_front();
               if (lbp_addr !== e.a || lbp_data !== e.d) begin
                  fails++;
                  $display("FAIL lbp_write got addr=%0d data=%h required addr=%0d data=%h",
                           lbp_addr, lbp_data, e.a, e.d);
               end
            end
         end
      end
   end

   function automatic logic [7:0] lbp_ref(input int r, input int c);
      logic [7:0] p, v;
      p = img[r*W + c];
      v[0] = img[(r-1)*W + c-1] >= p;
      v[1] = img[(r-1)*W + c  ] >= p;
      v[2] = img[(r-1)*W + c+1] >= p;
      v[3] = img[ r   *W + c-1] >= p;
      v[4] = img[ r   *W + c+1] >= p;
      v[5] = img[(r+1)*W + c-1] >= p;
      v[6] = img[(r+1)*W + c  ] >= p;
      v[7] = img[(r+1)*W + c+1] >= p;
      return v;
   endfunction

   task automatic push_expected(input logic mode, input int hand);
      exp_t e;
      for (int j = 0; j < N; j++) begin
         int r, c;
         r = j / W;
         c = j % W;
         e.a = AW'(j);
         if (r == 0 || r == H-1 || c == 0 || c == W-1) begin
            e.d = 8'h00;
            if (!mode) sbq.push_back(e);
         end else begin
            e.d = (hand >= 0) ? 8'(hand) : lbp_ref(r, c);
            sbq.push_back(e);
         end
      end
   endtask

   task automatic check_reset(input string name);
      checks++;
      if (gray_req !== 1'b0 || gray_addr !== '0 || lbp_valid !== 1'b0 ||
          lbp_addr !== '0 || lbp_data !== 8'h00 || finish !== 1'b0) begin
         fails++;
         $display("FAIL %s got req=%0b gaddr=%0d valid=%0b laddr=%0d data=%h finish=%0b required all 0",
                  name, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish);
      end
   endtask

   // hand >= 0 gives a hand-computed interior code; otherwise the reference model is used.
   task automatic run_frame(input logic mode, input int hand, input int stall_at, input int abort_at);
      int  stall_left, exp_outs, exp_lat;
      bit  stalled;
      reset_n = 1'b0;
      gray_ready = 1'b0;
      border_mode = mode;
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset_state");
      sbq.delete();
      push_expected(mode, hand);
      exp_outs = sbq.size();
      start_cyc = -1;
      fin_cyc = -1;
      outs = 0;
      stalled = 1'b0;
      stall_left = 0;
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      gray_ready = 1'b1;
      for (int t = 0; t < 2000 && fin_cyc < 0; t++) begin
         @(posedge clk);
         #1;
         if (abort_at > 0 && outs >= abort_at) begin
            reset_n = 1'b0;
            #1;
            check_reset("mid_frame_reset");
            sbq.delete();
            return;
         end
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) gray_ready = 1'b1;
         end else if (!stalled && stall_at >= 0 && gray_addr == AW'(stall_at)) begin
            gray_ready = 1'b0;
            stall_left = 7;
            stalled = 1'b1;
         end
      end
      exp_lat = N + W + 3 + (stalled ? 7 : 0);
      checks++;
      if (fin_cyc < 0) begin
         fails++;
         $display("FAIL finish_timeout finish=%0b required 1 within 2000 cycles", finish);
      end else if (fin_cyc - start_cyc != exp_lat) begin
         fails++;
         $display("FAIL finish_latency got %0d cycles required %0d", fin_cyc - start_cyc, exp_lat);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (gray_req !== 1'b0 || finish !== 1'b1) begin
         fails++;
         $display("FAIL done_state got req=%0b finish=%0b required req=0 finish=1", gray_req, finish);
      end
      checks++;
      if (sbq.size() != 0 || outs != exp_outs) begin
         fails++;
         $display("FAIL write_count got %0d writes (%0d pending) required %0d", outs, sbq.size(), exp_outs);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Ramp image: above/left neighbours smaller, below/right larger.
      for (int i = 0; i < N; i++) img[i] = 8'(i);
      run_frame(1'b0, 8'hF0, -1, 0);
      run_frame(1'b1, 8'hF0, -1, 0);
      // Constant image: equal neighbours all count as 1.
      for (int i = 0; i < N; i++) img[i] = 8'h55;
      run_frame(1'b0, 8'hFF, -1, 0);
      // Small value range forces many ties.
      for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 3));
      run_frame(1'b0, -1, -1, 0);
      for (int i = 0; i < N; i++) img[i] = 8'($urandom_range(0, 255));
      run_frame(1'b0, -1, -1, 0);
      run_frame(1'b0, -1, 200, 0);
      run_frame(1'b1, -1, 200, 0);
      run_frame(1'b0, -1, -1, 50);
      run_frame(1'b0, -1, -1, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
